switch_debounce_toggle_array: RTL and testbench



---
 rtl/switch_debounce_toggle_array.sv | 127 ++++++++++++
 tb/tb_switch_debounce_toggle_array.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_toggle_array.sv
// switch_debounce_toggle_array
// Multi-channel push-button to LED controller. Each raw switch is
// synchronised, debounced and drives one LED in a per-channel mode:
//   00 toggle on release, 01 toggle on press, 10 momentary,
//   11 debounced level gated by the previous channel's toggle state.
//
// Optional feature macro: SWITCH_EVENT_EN (adds o_event toggle pulses).
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_switch   [NUM_CH]    raw asynchronous switch levels, 1 = pressed
//   i_mode     [2*NUM_CH]  per-channel mode, bits [2n+1:2n] for channel n
//   o_led      [NUM_CH]    LED drive, combinational decode of registered state
//   o_event    [NUM_CH]    (SWITCH_EVENT_EN only) one-cycle pulse per toggle
module switch_debounce_toggle_array #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_CH-1:0]     i_switch,
    input  logic [2*NUM_CH-1:0]   i_mode,
`ifdef SWITCH_EVENT_EN
    output logic [NUM_CH-1:0]     o_event,
`endif
    output logic [NUM_CH-1:0]     o_led
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_RELEASE   = 2'b00;
    localparam logic [1:0] MODE_PRESS     = 2'b01;
    localparam logic [1:0] MODE_MOMENTARY = 2'b10;
    localparam logic [1:0] MODE_GATED     = 2'b11;

    // Per-channel state gathered so neighbours can see each other's toggle
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] tog;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam int unsigned PREV = (n + NUM_CH - 1) % NUM_CH;

        logic          sync1;
        logic          sync2;
        logic          db_q;
        logic          tog_q;
        logic [CW-1:0] cnt;
        logic          db_next;
        logic          tog_next;
        logic [CW-1:0] cnt_next;
        logic [1:0]    mode;

        assign mode   = i_mode[2*n +: 2];
        assign db[n]  = db_q;
        assign tog[n] = tog_q;

        // Debounce counter: a level is accepted only after it differs from
        // db for DEBOUNCE_CYCLES consecutive synchronised samples
        always_comb begin
            db_next  = db_q;
            tog_next = tog_q;
            cnt_next = '0;
            if (sync2 != db_q) begin
                if (cnt == CNT_LAST) begin
                    db_next = sync2;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            // Toggle evaluated against the db update of this same edge
            case (mode)
                MODE_RELEASE, MODE_GATED: begin
                    if (db_q && !db_next) tog_next = ~tog_q;
                end
                MODE_PRESS: begin
                    if (!db_q && db_next) tog_next = ~tog_q;
                end
                default: tog_next = tog_q;
            endcase
        end

        // Channel state registers
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                db_q  <= 1'b0;
                tog_q <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= i_switch[n];
                sync2 <= sync1;
                db_q  <= db_next;
                tog_q <= tog_next;
                cnt   <= cnt_next;
            end
        end

`ifdef SWITCH_EVENT_EN
        logic event_q;

        // Pulse is high in the cycle following the inverting edge
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                event_q <= 1'b0;
            end else begin
                event_q <= tog_next ^ tog_q;
            end
        end

        assign o_event[n] = event_q;
`endif

        // LED decode; a mode change shows up without a clock edge
        always_comb begin
            o_led[n] = tog_q;
            case (mode)
                MODE_MOMENTARY: o_led[n] = db_q;
                MODE_GATED:     o_led[n] = db_q & tog[PREV];
                default:        o_led[n] = tog_q;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_toggle_array.sv
// Scoreboard bench for switch_debounce_toggle_array (NUM_CH=4,
// DEBOUNCE_CYCLES=4). Each stimulus step drives inputs just after a rising
// edge and queues the hand-computed LED pattern for that cycle; the monitor
// pops and compares on the following falling edge.
module tb_switch_debounce_toggle_array;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DB_CYC = 4;

    bit                  clk;
    logic                reset;
    logic [NUM_CH-1:0]   sw;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   led;
`ifdef SWITCH_EVENT_EN
    logic [NUM_CH-1:0]   evt;
    int                  ev_cnt [NUM_CH];
`endif

    logic [2*NUM_CH-1:0] cur_mode;
    int                  phase;
    int                  step_no;
    int                  tests;
    int                  fails;
    logic                rst_at_edge;

    logic [NUM_CH-1:0]   exp_q   [$];
    int                  phase_q [$];
    int                  step_q  [$];

    switch_debounce_toggle_array #(
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_CYCLES(DB_CYC)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_switch(sw),
        .i_mode  (mode),
`ifdef SWITCH_EVENT_EN
        .o_event (evt),
`endif
        .o_led   (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge = reset;

    // Monitor: compare LEDs against the queued expectation each cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [NUM_CH-1:0] e;
            int ph;
            int st;
            e  = exp_q.pop_front();
            ph = phase_q.pop_front();
            st = step_q.pop_front();
            tests++;
            if (led !== e) begin
                fails++;
                $display("FAIL led phase%0d step%0d: got %b expected %b", ph, st, led, e);
            end
`ifdef SWITCH_EVENT_EN
            if (rst_at_edge) begin
                tests++;
                if (evt !== '0) begin
                    fails++;
                    $display("FAIL event_in_reset step%0d: got %b expected 0000", st, evt);
                end
            end
            for (int n = 0; n < NUM_CH; n++) if (evt[n] === 1'b1) ev_cnt[n]++;
`endif
        end
    end

    // n cycles of constant inputs with a constant expected LED pattern
    task automatic run(input logic [NUM_CH-1:0] s, input logic r, input int n,
                       input logic [NUM_CH-1:0] e);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sw    = s;
            reset = r;
            mode  = cur_mode;
            step_no++;
            exp_q.push_back(e);
            phase_q.push_back(phase);
            step_q.push_back(step_no);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        step_no  = 0;
`ifdef SWITCH_EVENT_EN
        for (int n = 0; n < NUM_CH; n++) ev_cnt[n] = 0;
`endif
        // ch3 gated, ch2 momentary, ch1 press, ch0 release
        cur_mode = 8'b11_10_01_00;
        mode     = cur_mode;
        sw       = '0;
        reset    = 1'b1;

        // Reset and idle
        phase = 1;
        run(4'b0000, 1'b1, 3, 4'b0000);
        run(4'b0000, 1'b0, 5, 4'b0000);

        // ch0 toggle on release, twice
        phase = 2;
        run(4'b0001, 1'b0, 20, 4'b0000);
        run(4'b0000, 1'b0, 6,  4'b0000);
        run(4'b0000, 1'b0, 5,  4'b0001);
        run(4'b0001, 1'b0, 20, 4'b0001);
        run(4'b0000, 1'b0, 6,  4'b0001);
        run(4'b0000, 1'b0, 5,  4'b0000);

        // ch1 toggle on press; 3-cycle glitch is rejected
        phase = 3;
        run(4'b0010, 1'b0, 3,  4'b0000);
        run(4'b0000, 1'b0, 10, 4'b0000);
        run(4'b0010, 1'b0, 6,  4'b0000);
        run(4'b0010, 1'b0, 4,  4'b0010);
        run(4'b0000, 1'b0, 6,  4'b0010);
        run(4'b0000, 1'b0, 5,  4'b0010);

        // ch2 momentary for 10 cycles, then switch to release mode
        phase = 4;
        run(4'b0100, 1'b0, 6, 4'b0010);
        run(4'b0100, 1'b0, 4, 4'b0110);
        run(4'b0000, 1'b0, 6, 4'b0110);
        run(4'b0000, 1'b0, 4, 4'b0010);
        cur_mode = 8'b11_00_01_00;
        run(4'b0000, 1'b0, 3, 4'b0010);

        // ch3 gated by tog[2]
        phase = 5;
        run(4'b0100, 1'b0, 20, 4'b0010);
        run(4'b0000, 1'b0, 6,  4'b0010);
        run(4'b0000, 1'b0, 5,  4'b0110);
        run(4'b1000, 1'b0, 6,  4'b0110);
        run(4'b1000, 1'b0, 4,  4'b1110);
        run(4'b1100, 1'b0, 20, 4'b1110);
        run(4'b1000, 1'b0, 6,  4'b1110);
        run(4'b1000, 1'b0, 5,  4'b0010);
        run(4'b0000, 1'b0, 11, 4'b0010);

        // Simultaneous events on ch0 and ch1
        phase = 6;
        run(4'b0011, 1'b0, 6, 4'b0010);
        run(4'b0011, 1'b0, 4, 4'b0000);
        run(4'b0000, 1'b0, 6, 4'b0000);
        run(4'b0000, 1'b0, 5, 4'b0001);

        // Reset mid-count on ch0, then switch held through reset release
        phase = 7;
        run(4'b0001, 1'b0, 4, 4'b0001);
        cur_mode = 8'b11_00_01_01;
        run(4'b0001, 1'b1, 1, 4'b0001);
        run(4'b0001, 1'b1, 2, 4'b0000);
        run(4'b0001, 1'b0, 6, 4'b0000);
        run(4'b0001, 1'b0, 3, 4'b0001);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

`ifdef SWITCH_EVENT_EN
        begin
            int exp_ev [NUM_CH];
            exp_ev[0] = 4;
            exp_ev[1] = 2;
            exp_ev[2] = 2;
            exp_ev[3] = 1;
            for (int n = 0; n < NUM_CH; n++) begin
                tests++;
                if (ev_cnt[n] != exp_ev[n]) begin
                    fails++;
                    $display("FAIL event_count ch%0d: got %0d expected %0d", n, ev_cnt[n], exp_ev[n]);
                end
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
